// File: rtl/xc_lsu_pkg.sv
// Shared encodings for the XCrypto scaled-indexed load/store stage.
package xc_lsu_pkg;

    localparam int unsigned LSU_XLEN = 32;
    localparam int unsigned CAUSE_W  = 6;

    // Access size encodings as presented by decode
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    // Store bus error has no override parameter
    localparam logic [CAUSE_W-1:0] CAUSE_BUS_ERR_ST = 6'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP
    } lsu_state_e;

    // Size code 3 is illegal and behaves as a word access
    function automatic logic [1:0] norm_size(input logic [1:0] sz);
        return (sz == 2'd3) ? SZ_W : sz;
    endfunction

endpackage

// File: rtl/xc_lsu_align.sv
// Alignment check, byte strobes and lane steering for load/store data.
module xc_lsu_align
    import xc_lsu_pkg::*;
(
    input  logic [1:0]          size,
    input  logic [1:0]          addr_lo,
    input  logic                ld_signed,
    input  logic [LSU_XLEN-1:0] st_data,
    input  logic [LSU_XLEN-1:0] ld_raw,
    output logic                misaligned,
    output logic [3:0]          strb,
    output logic [LSU_XLEN-1:0] st_lane,
    output logic [LSU_XLEN-1:0] ld_data
);

    logic [4:0]          lane_shift;
    logic [LSU_XLEN-1:0] ld_shifted;

    // Shift data to/from its byte lane, then size-check and extend
    always_comb begin
        lane_shift = {addr_lo, 3'b000};
        st_lane    = st_data << lane_shift;
        ld_shifted = ld_raw >> lane_shift;
        misaligned = 1'b0;
        strb       = 4'b1111;
        ld_data    = ld_shifted;
        case (size)
            SZ_B: begin
                strb    = 4'b0001 << addr_lo;
                ld_data = {{24{ld_signed & ld_shifted[7]}}, ld_shifted[7:0]};
            end
            SZ_H: begin
                misaligned = addr_lo[0];
                strb       = 4'b0011 << {addr_lo[1], 1'b0};
                ld_data    = {{16{ld_signed & ld_shifted[15]}}, ld_shifted[15:0]};
            end
            default: begin
                misaligned = (addr_lo != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/xc_lsu_idx.sv
// Memory-access stage for xc.ldr.* / xc.str.*: address = rs1 + (rs2 << size),
// one outstanding bus transaction, registered result to retire.
module xc_lsu_idx
    import xc_lsu_pkg::*;
#(
    parameter int unsigned XLEN                  = LSU_XLEN,
    parameter int unsigned TRAP_CODE_MISALIGN_LD = 4,
    parameter int unsigned TRAP_CODE_MISALIGN_ST = 6,
    parameter int unsigned TRAP_CODE_BUS_ERR_LD  = 5
) (
    input  logic                g_clk,
    input  logic                g_reset,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic                s_store,
    input  logic [1:0]          s_size,
    input  logic                s_signed,
    input  logic [XLEN-1:0]     s_rs1,
    input  logic [XLEN-1:0]     s_rs2,
    input  logic [XLEN-1:0]     s_rs3,
    input  logic [4:0]          s_rd,
    output logic                dmem_req,
    input  logic                dmem_gnt,
    output logic                dmem_wen,
    output logic [3:0]          dmem_strb,
    output logic [XLEN-1:0]     dmem_addr,
    output logic [XLEN-1:0]     dmem_wdata,
    input  logic                dmem_recv,
    input  logic                dmem_error,
    input  logic [XLEN-1:0]     dmem_rdata,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [4:0]          m_rd,
    output logic [XLEN-1:0]     m_wdata,
    output logic                m_trap,
    output logic [CAUSE_W-1:0]  m_cause,
    output logic [XLEN-1:0]     m_addr
);

    lsu_state_e          state_q, state_d;
    logic                store_q, store_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [4:0]          rd_q, rd_d;
    logic [XLEN-1:0]     addr_q, addr_d;

    logic                s_ready_q, s_ready_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_wen_q, dmem_wen_d;
    logic [3:0]          dmem_strb_q, dmem_strb_d;
    logic [XLEN-1:0]     dmem_addr_q, dmem_addr_d;
    logic [XLEN-1:0]     dmem_wdata_q, dmem_wdata_d;
    logic                m_valid_q, m_valid_d;
    logic [4:0]          m_rd_q, m_rd_d;
    logic [XLEN-1:0]     m_wdata_q, m_wdata_d;
    logic                m_trap_q, m_trap_d;
    logic [CAUSE_W-1:0]  m_cause_q, m_cause_d;
    logic [XLEN-1:0]     m_addr_q, m_addr_d;

    logic [1:0]          in_size;
    logic [XLEN-1:0]     addr_byte;
    logic [1:0]          fmt_size;
    logic [1:0]          fmt_lo;
    logic                fmt_mis;
    logic [3:0]          fmt_strb;
    logic [XLEN-1:0]     fmt_wdata;
    logic [XLEN-1:0]     fmt_ldata;
    logic                take_resp;

    // Effective address; formatter sees live operands in IDLE, latched ones after
    always_comb begin
        in_size   = norm_size(s_size);
        addr_byte = s_rs1 + (s_rs2 << in_size);
        fmt_size  = (state_q == ST_IDLE) ? in_size : size_q;
        fmt_lo    = (state_q == ST_IDLE) ? addr_byte[1:0] : addr_q[1:0];
    end

    xc_lsu_align u_align (
        .size       (fmt_size),
        .addr_lo    (fmt_lo),
        .ld_signed  (signed_q),
        .st_data    (s_rs3),
        .ld_raw     (dmem_rdata),
        .misaligned (fmt_mis),
        .strb       (fmt_strb),
        .st_lane    (fmt_wdata),
        .ld_data    (fmt_ldata)
    );

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        size_d       = size_q;
        signed_d     = signed_q;
        rd_d         = rd_q;
        addr_d       = addr_q;
        dmem_req_d   = dmem_req_q;
        dmem_wen_d   = dmem_wen_q;
        dmem_strb_d  = dmem_strb_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        m_valid_d    = m_valid_q;
        m_rd_d       = m_rd_q;
        m_wdata_d    = m_wdata_q;
        m_trap_d     = m_trap_q;
        m_cause_d    = m_cause_q;
        m_addr_d     = m_addr_q;
        take_resp    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (s_valid) begin
                    store_d  = s_store;
                    size_d   = in_size;
                    signed_d = s_signed;
                    rd_d     = s_rd;
                    addr_d   = addr_byte;
                    if (fmt_mis) begin
                        state_d   = ST_RESP;
                        m_valid_d = 1'b1;
                        m_trap_d  = 1'b1;
                        m_cause_d = s_store ? CAUSE_W'(TRAP_CODE_MISALIGN_ST)
                                            : CAUSE_W'(TRAP_CODE_MISALIGN_LD);
                        m_rd_d    = 5'd0;
                        m_wdata_d = '0;
                        m_addr_d  = addr_byte;
                    end else begin
                        state_d      = ST_REQ;
                        dmem_req_d   = 1'b1;
                        dmem_wen_d   = s_store;
                        dmem_addr_d  = {addr_byte[XLEN-1:2], 2'b00};
                        dmem_strb_d  = s_store ? fmt_strb : 4'b1111;
                        dmem_wdata_d = s_store ? fmt_wdata : '0;
                    end
                end
            end
            ST_REQ: begin
                if (dmem_gnt) begin
                    dmem_req_d   = 1'b0;
                    dmem_wen_d   = 1'b0;
                    dmem_strb_d  = 4'b0000;
                    dmem_addr_d  = '0;
                    dmem_wdata_d = '0;
                    state_d      = ST_WAIT;
                    take_resp    = dmem_recv;
                end
            end
            ST_WAIT: begin
                take_resp = dmem_recv;
            end
            ST_RESP: begin
                if (m_ready) begin
                    state_d   = ST_IDLE;
                    m_valid_d = 1'b0;
                    m_rd_d    = 5'd0;
                    m_wdata_d = '0;
                    m_trap_d  = 1'b0;
                    m_cause_d = '0;
                    m_addr_d  = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus response captured into the result registers
        if (take_resp) begin
            state_d   = ST_RESP;
            m_valid_d = 1'b1;
            m_addr_d  = addr_q;
            m_trap_d  = dmem_error;
            if (dmem_error) begin
                m_cause_d = store_q ? CAUSE_BUS_ERR_ST : CAUSE_W'(TRAP_CODE_BUS_ERR_LD);
                m_rd_d    = 5'd0;
                m_wdata_d = '0;
            end else begin
                m_cause_d = '0;
                m_rd_d    = store_q ? 5'd0 : rd_q;
                m_wdata_d = store_q ? '0 : fmt_ldata;
            end
        end

        s_ready_d = (state_d == ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q      <= ST_IDLE;
            store_q      <= 1'b0;
            size_q       <= SZ_B;
            signed_q     <= 1'b0;
            rd_q         <= 5'd0;
            addr_q       <= '0;
            s_ready_q    <= 1'b1;
            dmem_req_q   <= 1'b0;
            dmem_wen_q   <= 1'b0;
            dmem_strb_q  <= 4'b0000;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            m_valid_q    <= 1'b0;
            m_rd_q       <= 5'd0;
            m_wdata_q    <= '0;
            m_trap_q     <= 1'b0;
            m_cause_q    <= '0;
            m_addr_q     <= '0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            size_q       <= size_d;
            signed_q     <= signed_d;
            rd_q         <= rd_d;
            addr_q       <= addr_d;
            s_ready_q    <= s_ready_d;
            dmem_req_q   <= dmem_req_d;
            dmem_wen_q   <= dmem_wen_d;
            dmem_strb_q  <= dmem_strb_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            m_valid_q    <= m_valid_d;
            m_rd_q       <= m_rd_d;
            m_wdata_q    <= m_wdata_d;
            m_trap_q     <= m_trap_d;
            m_cause_q    <= m_cause_d;
            m_addr_q     <= m_addr_d;
        end
    end

    assign s_ready    = s_ready_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_wen   = dmem_wen_q;
    assign dmem_strb  = dmem_strb_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign m_valid    = m_valid_q;
    assign m_rd       = m_rd_q;
    assign m_wdata    = m_wdata_q;
    assign m_trap     = m_trap_q;
    assign m_cause    = m_cause_q;
    assign m_addr     = m_addr_q;

endmodule

// File: tb/tb_xc_lsu_idx.sv
// Directed bench for xc_lsu_idx.
module tb_xc_lsu_idx;

    logic        g_clk = 1'b0;
    logic        g_reset;
    logic        s_valid, s_ready, s_store, s_signed;
    logic [1:0]  s_size;
    logic [31:0] s_rs1, s_rs2, s_rs3;
    logic [4:0]  s_rd;
    logic        dmem_req, dmem_gnt, dmem_wen, dmem_recv, dmem_error;
    logic [3:0]  dmem_strb;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic        m_valid, m_ready, m_trap;
    logic [4:0]  m_rd;
    logic [31:0] m_wdata, m_addr;
    logic [5:0]  m_cause;

    int checks   = 0;
    int failures = 0;

    xc_lsu_idx dut (
        .g_clk      (g_clk),
        .g_reset    (g_reset),
        .s_valid    (s_valid),
        .s_ready    (s_ready),
        .s_store    (s_store),
        .s_size     (s_size),
        .s_signed   (s_signed),
        .s_rs1      (s_rs1),
        .s_rs2      (s_rs2),
        .s_rs3      (s_rs3),
        .s_rd       (s_rd),
        .dmem_req   (dmem_req),
        .dmem_gnt   (dmem_gnt),
        .dmem_wen   (dmem_wen),
        .dmem_strb  (dmem_strb),
        .dmem_addr  (dmem_addr),
        .dmem_wdata (dmem_wdata),
        .dmem_recv  (dmem_recv),
        .dmem_error (dmem_error),
        .dmem_rdata (dmem_rdata),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_rd       (m_rd),
        .m_wdata    (m_wdata),
        .m_trap     (m_trap),
        .m_cause    (m_cause),
        .m_addr     (m_addr)
    );

    always #5 g_clk = ~g_clk;

    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Offer one instruction for a single cycle
    task automatic accept(input logic st, input logic [1:0] sz, input logic sg,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] r3, input logic [4:0] rd);
        s_valid  = 1'b1;
        s_store  = st;
        s_size   = sz;
        s_signed = sg;
        s_rs1    = r1;
        s_rs2    = r2;
        s_rs3    = r3;
        s_rd     = rd;
        tick();
        s_valid  = 1'b0;
    endtask

    // Grant and respond in the same cycle
    task automatic bus_resp(input logic [31:0] rd_data, input logic err);
        dmem_gnt   = 1'b1;
        dmem_recv  = 1'b1;
        dmem_rdata = rd_data;
        dmem_error = err;
        tick();
        dmem_gnt   = 1'b0;
        dmem_recv  = 1'b0;
        dmem_error = 1'b0;
        dmem_rdata = 32'h0;
    endtask

    task automatic retire();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
    endtask

    initial begin
        g_reset = 1'b1; s_valid = 1'b0; s_store = 1'b0; s_size = 2'd0; s_signed = 1'b0;
        s_rs1 = 32'h0; s_rs2 = 32'h0; s_rs3 = 32'h0; s_rd = 5'd0;
        dmem_gnt = 1'b0; dmem_recv = 1'b0; dmem_error = 1'b0; dmem_rdata = 32'h0;
        m_ready = 1'b0;
        tick(); tick();
        g_reset = 1'b0;

        // Reset state
        chk("rst_s_ready", 32'(s_ready), 32'd1);
        chk("rst_req", 32'(dmem_req), 32'd0);
        chk("rst_m_valid", 32'(m_valid), 32'd0);
        chk("rst_strb", 32'(dmem_strb), 32'd0);
        chk("rst_m_wdata", m_wdata, 32'h0);

        // str.w, gnt+recv same cycle
        accept(1'b1, 2'd2, 1'b0, 32'h1000, 32'd3, 32'hDEADBEEF, 5'd9);
        chk("sw_req", 32'(dmem_req), 32'd1);
        chk("sw_addr", dmem_addr, 32'h100C);
        chk("sw_strb", 32'(dmem_strb), 32'hF);
        chk("sw_wdata", dmem_wdata, 32'hDEADBEEF);
        chk("sw_wen", 32'(dmem_wen), 32'd1);
        chk("sw_s_ready", 32'(s_ready), 32'd0);
        chk("sw_mvalid_early", 32'(m_valid), 32'd0);
        bus_resp(32'h0, 1'b0);
        chk("sw_mvalid", 32'(m_valid), 32'd1);
        chk("sw_trap", 32'(m_trap), 32'd0);
        chk("sw_rd", 32'(m_rd), 32'd0);
        chk("sw_req_off", 32'(dmem_req), 32'd0);
        retire();
        chk("sw_done", 32'(m_valid), 32'd0);
        chk("sw_ready", 32'(s_ready), 32'd1);

        // ldr.b signed
        accept(1'b0, 2'd0, 1'b1, 32'h2001, 32'd2, 32'h0, 5'd5);
        chk("lb_addr", dmem_addr, 32'h2000);
        chk("lb_strb", 32'(dmem_strb), 32'hF);
        chk("lb_wen", 32'(dmem_wen), 32'd0);
        chk("lb_wdata", dmem_wdata, 32'h0);
        bus_resp(32'h80FF7F00, 1'b0);
        chk("lb_data", m_wdata, 32'hFFFFFF80);
        chk("lb_rd", 32'(m_rd), 32'd5);
        chk("lb_maddr", m_addr, 32'h2003);
        retire();

        // ldr.bu
        accept(1'b0, 2'd0, 1'b0, 32'h2001, 32'd2, 32'h0, 5'd5);
        bus_resp(32'h80FF7F00, 1'b0);
        chk("lbu_data", m_wdata, 32'h00000080);
        retire();

        // ldr.h signed at byte offset 2
        accept(1'b0, 2'd1, 1'b1, 32'h6000, 32'd1, 32'h0, 5'd3);
        bus_resp(32'h80011234, 1'b0);
        chk("lh_data", m_wdata, 32'hFFFF8001);
        retire();

        // str.h upper half, response one cycle after grant
        accept(1'b1, 2'd1, 1'b0, 32'h3000, 32'd1, 32'h00001234, 5'd1);
        chk("sh_addr", dmem_addr, 32'h3000);
        chk("sh_strb", 32'(dmem_strb), 32'hC);
        chk("sh_wdata", dmem_wdata, 32'h12340000);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        chk("sh_wait_req", 32'(dmem_req), 32'd0);
        chk("sh_wait_mvalid", 32'(m_valid), 32'd0);
        dmem_recv = 1'b1;
        tick();
        dmem_recv = 1'b0;
        chk("sh_mvalid", 32'(m_valid), 32'd1);
        chk("sh_rd", 32'(m_rd), 32'd0);
        retire();

        // str.w misaligned: trap 6 one cycle after accept, no bus request
        accept(1'b1, 2'd2, 1'b0, 32'h3001, 32'd1, 32'h0, 5'd0);
        chk("mis_mvalid", 32'(m_valid), 32'd1);
        chk("mis_trap", 32'(m_trap), 32'd1);
        chk("mis_cause", 32'(m_cause), 32'd6);
        chk("mis_maddr", m_addr, 32'h3005);
        chk("mis_req", 32'(dmem_req), 32'd0);
        retire();

        // Grant stalled 5 cycles, recv 3 cycles after grant
        accept(1'b0, 2'd2, 1'b0, 32'h4000, 32'd0, 32'h0, 5'd7);
        for (int i = 0; i < 5; i++) begin
            chk("stall_req", 32'(dmem_req), 32'd1);
            chk("stall_addr", dmem_addr, 32'h4000);
            chk("stall_strb", 32'(dmem_strb), 32'hF);
            chk("stall_wdata", dmem_wdata, 32'h0);
            chk("stall_s_ready", 32'(s_ready), 32'd0);
            tick();
        end
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk("stall_wait_mvalid", 32'(m_valid), 32'd0);
            chk("stall_wait_s_ready", 32'(s_ready), 32'd0);
            tick();
        end
        dmem_recv  = 1'b1;
        dmem_rdata = 32'hCAFEF00D;
        tick();
        dmem_recv  = 1'b0;
        dmem_rdata = 32'h0;
        chk("stall_mvalid", 32'(m_valid), 32'd1);
        chk("stall_data", m_wdata, 32'hCAFEF00D);
        chk("stall_rd", 32'(m_rd), 32'd7);
        retire();
        chk("stall_single", 32'(m_valid), 32'd0);

        // Load bus error with retire back-pressure
        accept(1'b0, 2'd2, 1'b0, 32'h5000, 32'd0, 32'h0, 5'd4);
        bus_resp(32'h12345678, 1'b1);
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("err_mvalid", 32'(m_valid), 32'd1);
            chk("err_trap", 32'(m_trap), 32'd1);
            chk("err_cause", 32'(m_cause), 32'd5);
            chk("err_rd", 32'(m_rd), 32'd0);
            chk("err_wdata", m_wdata, 32'h0);
            chk("err_s_ready", 32'(s_ready), 32'd0);
            chk("err_req", 32'(dmem_req), 32'd0);
            tick();
        end
        s_valid = 1'b0;
        retire();
        chk("err_done", 32'(m_valid), 32'd0);

        // Reset while waiting, then stray response in IDLE
        accept(1'b0, 2'd2, 1'b0, 32'h7000, 32'd0, 32'h0, 5'd2);
        dmem_gnt = 1'b1;
        tick();
        dmem_gnt = 1'b0;
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        chk("rw_s_ready", 32'(s_ready), 32'd1);
        chk("rw_req", 32'(dmem_req), 32'd0);
        dmem_recv  = 1'b1;
        dmem_rdata = 32'hFFFFFFFF;
        tick();
        dmem_recv  = 1'b0;
        chk("rw_mvalid", 32'(m_valid), 32'd0);
        chk("rw_s_ready2", 32'(s_ready), 32'd1);
        chk("rw_req2", 32'(dmem_req), 32'd0);
        tick();
        chk("rw_mvalid2", 32'(m_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
